seq_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern-detector stage. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on `serial_x`, which drives the detector's `input_x` directly. A one-word holding register lets back-to-back words stream with no idle gap, so patterns that span word boundaries reach the detector intact. When no data is pending, the line idles at IDLE_BIT.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_serializer_if.sv | 22 ++
 rtl/seq_serializer.sv | 133 +++++++++++++
 tb/tb_seq_serializer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern-detector path:
// serializer FSM states, default idle level and the detector's target pattern.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } seq_state_e;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  localparam int             PATTERN_LEN = 5;
  localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b10011;

  localparam logic [15:0] WORDS_SENT_MAX = 16'hFFFF;

endpackage

// File: rtl/seq_serializer_if.sv
// Valid/ready word handshake into the serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end feeding the pattern detector's input_x, with a
// one-word holding register so consecutive words stream without an idle gap.
//
// state | meaning
// IDLE  | shifter empty; serial_x at IDLE_BIT, serial_active low
// SHIFT | serial_x carries bit cnt of the current word
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  seq_serializer_if.slave   in_bus,
  output logic              serial_x,
  output logic              serial_active,
  output logic              word_done,
  output logic [15:0]       words_sent
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_e       state;
  seq_state_e       state_next;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] hold_next;
  logic             hold_full;
  logic             hold_full_next;
  logic             serial_x_next;
  logic             serial_active_next;

  logic             transfer;
  logic             shifter_free;
  logic             load_hold;
  logic             load_in;
  logic             write_hold;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] load_ordered;

  // Reorders a word so the first bit to emit always sits in the MSB.
  function automatic logic [WIDTH-1:0] emit_order(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = MSB_FIRST ? w[i] : w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign in_bus.in_ready = !hold_full;
  assign word_done       = serial_active && (cnt == CNT_LAST);

  always_comb begin
    transfer     = in_bus.in_valid && !hold_full;
    shifter_free = (state == IDLE) || (cnt == CNT_LAST);
    load_hold    = shifter_free && hold_full;
    load_in      = shifter_free && !hold_full && transfer;
    write_hold   = transfer && !load_in;
    load_word    = load_hold ? hold : in_bus.in_data;
    load_ordered = emit_order(load_word);
  end

  always_comb begin
    state_next         = state;
    sh_next            = sh;
    cnt_next           = cnt;
    hold_next          = hold;
    hold_full_next     = hold_full;
    serial_x_next      = serial_x;
    serial_active_next = serial_active;

    if (load_hold || load_in) begin
      state_next         = SHIFT;
      serial_x_next      = load_ordered[WIDTH-1];
      sh_next            = load_ordered << 1;
      cnt_next           = '0;
      serial_active_next = 1'b1;
    end else if (state == SHIFT && !shifter_free) begin
      serial_x_next      = sh[WIDTH-1];
      sh_next            = sh << 1;
      cnt_next           = cnt + CNT_W'(1);
    end else begin
      state_next         = IDLE;
      serial_x_next      = IDLE_BIT;
      serial_active_next = 1'b0;
      cnt_next           = '0;
    end

    // Draining and refilling hold on one edge: the new word wins the flag.
    if (load_hold) begin
      hold_full_next = 1'b0;
    end
    if (write_hold) begin
      hold_next      = in_bus.in_data;
      hold_full_next = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sh            <= '0;
      cnt           <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      serial_x      <= IDLE_BIT;
      serial_active <= 1'b0;
    end else begin
      state         <= state_next;
      sh            <= sh_next;
      cnt           <= cnt_next;
      hold          <= hold_next;
      hold_full     <= hold_full_next;
      serial_x      <= serial_x_next;
      serial_active <= serial_active_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      words_sent <= '0;
    end else if (word_done && words_sent != WORDS_SENT_MAX) begin
      words_sent <= words_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share one stimulus
// stream and are checked each cycle against a bit-queue model of the output line.
module tb_seq_serializer;
  import seq_pkg::*;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             v     = 1'b0;
  logic [WIDTH-1:0] d     = '0;

  logic        a_sx, a_act, a_wd;
  logic [15:0] a_ws;
  logic        b_sx, b_act, b_wd;
  logic [15:0] b_ws;

  seq_serializer_if #(.WIDTH(WIDTH)) bus_a ();
  seq_serializer_if #(.WIDTH(WIDTH)) bus_b ();

  assign bus_a.in_valid = v;
  assign bus_a.in_data  = d;
  assign bus_b.in_valid = v;
  assign bus_b.in_data  = d;

  seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
    .clock(clock), .reset(reset), .in_bus(bus_a),
    .serial_x(a_sx), .serial_active(a_act), .word_done(a_wd), .words_sent(a_ws)
  );

  seq_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
    .clock(clock), .reset(reset), .in_bus(bus_b),
    .serial_x(b_sx), .serial_active(b_act), .word_done(b_wd), .words_sent(b_ws)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: bits still owed on the line; front entry is the bit on display now.
  bit qa[$];
  bit qb[$];
  bit ql[$];
  int m_ws = 0;

  bit         ca[$];
  bit         cb[$];
  logic [4:0] ha = '0;
  logic [4:0] hb = '0;
  int         za = 0;
  int         zb = 0;

  function automatic bit m_ready();
    return qa.size() <= WIDTH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input bit sel, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      if (sel) r = {r[30:0], (i < cb.size()) ? cb[i] : 1'b1};
      else     r = {r[30:0], (i < ca.size()) ? ca[i] : 1'b1};
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        qa.delete(); qb.delete(); ql.delete();
        m_ws = 0;
      end else begin
        bit acc;
        acc = v && m_ready();
        if (qa.size() > 0) begin
          if (ql[0] && m_ws < 32'hFFFF) m_ws++;
          void'(qa.pop_front());
          void'(qb.pop_front());
          void'(ql.pop_front());
        end
        if (acc) begin
          for (int i = 0; i < WIDTH; i++) begin
            qa.push_back(d[WIDTH-1-i]);
            qb.push_back(d[i]);
            ql.push_back(i == WIDTH - 1);
          end
        end
      end
    end
  end

  initial begin
    @(negedge clock);
    forever begin
      chk("a_serial_x",      a_sx,           (qa.size() > 0) ? qa[0] : 1'b0);
      chk("b_serial_x",      b_sx,           (qb.size() > 0) ? qb[0] : 1'b0);
      chk("a_serial_active", a_act,          qa.size() > 0);
      chk("b_serial_active", b_act,          qb.size() > 0);
      chk("a_word_done",     a_wd,           (ql.size() > 0) && ql[0]);
      chk("b_word_done",     b_wd,           (ql.size() > 0) && ql[0]);
      chk("a_in_ready",      bus_a.in_ready, m_ready());
      chk("b_in_ready",      bus_b.in_ready, m_ready());
      chk("a_words_sent",    a_ws,           m_ws);
      chk("b_words_sent",    b_ws,           m_ws);
      ca.push_back(a_sx);
      cb.push_back(b_sx);
      ha = {ha[3:0], a_sx};
      hb = {hb[3:0], b_sx};
      if (ha == PATTERN) za++;
      if (hb == PATTERN) zb++;
      @(negedge clock);
    end
  end

  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    v = 1'b1;
    d = w;
    while (!m_ready() && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: word %0h still not accepted after %0d cycles", w, n);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    v = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic start_capture();
    @(posedge clock);
    ca.delete();
    cb.delete();
    za = 0;
    zb = 0;
    @(negedge clock);
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int ones_a;
    int ones_b;

    repeat (3) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("idle_serial_x", a_sx, 0);
      chk("idle_active",   a_act, 0);
      chk("idle_in_ready", bus_a.in_ready, 1);
      chk("idle_words",    a_ws, 0);
    end

    start_capture();
    send(8'b1001_1000);
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("single_word_done", a_wd, i == 7);
      @(negedge clock);
    end
    idle(4);
    sync();
    chk("single_stream_a", pack(1'b0, 10), 10'b0_1001_1000_0);
    chk("single_stream_b", pack(1'b1, 10), 10'b0_0001_1001_0);
    chk("single_detect",   za, 1);
    chk("single_words",    a_ws, 1);

    start_capture();
    send(8'h13);
    send(8'h98);
    v = 1'b0;
    for (int e = 2; e <= 18; e++) begin
      chk("b2b_in_ready", bus_a.in_ready, e >= 9);
      @(negedge clock);
    end
    sync();
    chk("b2b_stream_a", pack(1'b0, 18), {1'b0, 16'h1398, 1'b0});
    chk("b2b_stream_b", pack(1'b1, 18), {1'b0, 16'hC819, 1'b0});
    chk("b2b_detect",   za, 2);
    chk("b2b_words",    a_ws, 3);

    start_capture();
    send(8'h01);
    send(8'h38);
    idle(18);
    sync();
    chk("span_stream_a", pack(1'b0, 18), {1'b0, 16'h0138, 1'b0});
    chk("span_stream_b", pack(1'b1, 18), {1'b0, 16'h801C, 1'b0});
    chk("span_detect",   za, 1);
    chk("span_words",    a_ws, 5);

    start_capture();
    send(8'h19);
    idle(10);
    sync();
    chk("lsb_stream_b", pack(1'b1, 10), 10'b0_1001_1000_0);
    chk("lsb_stream_a", pack(1'b0, 10), 10'b0_0001_1001_0);
    chk("lsb_detect_b", zb, 1);
    chk("lsb_detect_a", za, 0);
    chk("lsb_words_b",  b_ws, 6);

    start_capture();
    send(8'hA5);
    send(8'h3C);
    chk("rst_hold_full", bus_a.in_ready, 0);
    v = 1'b0;
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    chk("rst_serial_x_a", a_sx, 0);
    chk("rst_active_a",   a_act, 0);
    chk("rst_in_ready_a", bus_a.in_ready, 1);
    chk("rst_serial_x_b", b_sx, 0);
    chk("rst_in_ready_b", bus_b.in_ready, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idle(12);
    sync();
    chk("rst_partial_a", pack(1'b0, 5), 5'b01010);
    chk("rst_partial_b", pack(1'b1, 5), 5'b01010);
    ones_a = 0;
    ones_b = 0;
    for (int i = 5; i < ca.size(); i++) ones_a += int'(ca[i]);
    for (int i = 5; i < cb.size(); i++) ones_b += int'(cb[i]);
    chk("rst_capture_len", ca.size() >= 18, 1);
    chk("rst_no_tail_a",   ones_a, 0);
    chk("rst_no_tail_b",   ones_b, 0);
    chk("rst_words",       a_ws, 0);
    chk("rst_active_end",  a_act, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
